// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution for the accumulator processor: sequential
// fetch, LUT-based absolute branch targets, halt, and a saturating retire counter.
module pc_branch_unit #(
  parameter int PC_W       = 10,
  parameter int LUT_DEPTH  = 16,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         halt_in,
  input  logic                         branch_en,
  input  logic                         zero_in,
  input  logic [$clog2(LUT_DEPTH)-1:0] branch_sel,
  input  logic                         lut_wr_en,
  input  logic [$clog2(LUT_DEPTH)-1:0] lut_wr_idx,
  input  logic [PC_W-1:0]              lut_wr_data,
  output logic [PC_W-1:0]              pc_out,
  output logic                         running_out,
  output logic                         done_out,
  output logic [CNT_W-1:0]             retired_out
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [PC_W-1:0]   lut_q [LUT_DEPTH];
  logic [PC_W-1:0]   target;
  logic [CNT_W-1:0]  retired_inc;

  // Reads see the pre-write contents, so a same-cycle write is visible next cycle.
  assign target      = lut_q[branch_sel];
  assign retired_inc = (retired_q == {CNT_W{1'b1}}) ? retired_q : retired_q + CNT_W'(1);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else if (lut_wr_en) begin
      lut_q[lut_wr_idx] <= lut_wr_data;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d   = RUN;
          pc_d      = START_PC;
          retired_d = '0;
        end
      end
      RUN: begin
        if (start) begin
          pc_d      = START_PC;
          retired_d = '0;
        end else if (halt_in) begin
          state_d   = HALTED;
          retired_d = retired_inc;
        end else begin
          pc_d      = (branch_en && zero_in) ? target : pc_q + PC_W'(1);
          retired_d = retired_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_out      = pc_q;
    retired_out = retired_q;
    running_out = (state_q == RUN);
    done_out    = (state_q == HALTED);
  end

endmodule
